// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame-capture path.
// Default frame geometry, FSM state and sticky error encodings.
package vga_pkg;

  localparam int unsigned DefaultWidth  = 320;
  localparam int unsigned DefaultHeight = 240;
  localparam int unsigned NumPixels     = DefaultWidth * DefaultHeight;
  localparam int unsigned AddrWidth     = 17;
  localparam int unsigned PixelBits     = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEEK_SOP = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DONE     = 2'd3
  } cap_state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SHORT  = 2'd1,
    ERR_LONG   = 2'd2,
    ERR_RESYNC = 2'd3
  } cap_err_e;

  function automatic int unsigned num_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Keep only the MSB of each 10-bit channel {R,G,B}.
  function automatic logic [2:0] quantise(input logic [29:0] px);
    return {px[29], px[19], px[9]};
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
// No reset: contents survive a design reset.
module frame_buffer_ram #(
  parameter int unsigned Depth     = 76800,
  parameter int unsigned AddrWidth = 17,
  parameter int unsigned DataWidth = 3
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [AddrWidth-1:0] i_raddr,
  output logic [DataWidth-1:0] o_rdata
);

  localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [DataWidth-1:0] r_rdata;
  logic                 w_unused_addr;

  // Upper address bits beyond the array depth carry no information.
  assign w_unused_addr = ^{i_raddr, i_waddr};

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr[IdxWidth-1:0]] <= i_wdata;
    end
  end

  // Registered read; a same-cycle write to this address returns old data.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr[IdxWidth-1:0]];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_capture.sv
// Captures one Avalon-ST video frame into a 3-bit-per-pixel buffer,
// flagging short, long and resynchronised frames with a sticky error code.
module frame_capture
  import vga_pkg::*;
#(
  parameter int unsigned FrameWidth  = 320,
  parameter int unsigned FrameHeight = 240,
  parameter bit          Continuous  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] data,
  input  logic        startofpacket,
  input  logic        endofpacket,
  input  logic        valid,
  output logic        ready,
  input  logic        capture_en,
  output logic        frame_done,
  output logic [1:0]  error_code,
  output logic [16:0] pixel_count,
  input  logic [16:0] rd_addr,
  output logic [2:0]  rd_data
);

  localparam int unsigned NPix     = num_pixels(FrameWidth, FrameHeight);
  localparam logic [16:0] LastAddr = 17'(NPix - 1);

  cap_state_e  r_state, w_state_nxt;
  cap_err_e    r_err, w_err_nxt;
  logic [16:0] r_count, w_count_nxt;
  logic        r_ready, r_frame_done;
  logic        w_fire, w_we, w_good;
  logic [16:0] w_addr;
  logic [2:0]  w_pix;
  logic        w_unused_data;

  assign w_fire        = valid & r_ready;
  assign w_pix         = quantise(data);
  assign w_unused_data = ^{data[28:20], data[18:10], data[8:0]};

  // Next-state, buffer write and error decisions for the current beat.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_count_nxt = r_count;
    w_addr      = r_count;
    w_we        = 1'b0;
    w_good      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (capture_en) begin
          w_state_nxt = ST_SEEK_SOP;
          w_err_nxt   = ERR_NONE;
          w_count_nxt = 17'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEEK_SOP: begin
        if (w_fire && startofpacket) begin
          w_addr      = 17'd0;
          w_we        = 1'b1;
          w_count_nxt = 17'd1;
          if (endofpacket) begin
            w_err_nxt   = ERR_SHORT;
            w_state_nxt = ST_SEEK_SOP;
          end else begin
            w_state_nxt = ST_CAPTURE;
          end
        end else begin
          w_state_nxt = ST_SEEK_SOP;
        end
      end
      ST_CAPTURE: begin
        if (!w_fire) begin
          w_state_nxt = ST_CAPTURE;
        end else if (startofpacket) begin
          // A fresh SOP restarts the frame from address 0.
          w_addr      = 17'd0;
          w_we        = 1'b1;
          w_count_nxt = 17'd1;
          w_err_nxt   = ERR_RESYNC;
        end else if (endofpacket) begin
          w_we        = 1'b1;
          w_count_nxt = r_count + 17'd1;
          if (r_count == LastAddr) begin
            w_good      = 1'b1;
            w_state_nxt = Continuous ? ST_SEEK_SOP : ST_DONE;
          end else begin
            w_err_nxt   = ERR_SHORT;
            w_state_nxt = ST_SEEK_SOP;
          end
        end else if (r_count == LastAddr) begin
          // Overrun: the beat that should have carried EOP is dropped.
          w_err_nxt   = ERR_LONG;
          w_state_nxt = ST_SEEK_SOP;
        end else begin
          w_we        = 1'b1;
          w_count_nxt = r_count + 17'd1;
        end
      end
      ST_DONE: begin
        if (capture_en && !Continuous) begin
          w_state_nxt = ST_SEEK_SOP;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, handshake and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_err        <= ERR_NONE;
      r_count      <= 17'd0;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_err        <= w_err_nxt;
      r_count      <= w_count_nxt;
      r_ready      <= (w_state_nxt == ST_SEEK_SOP) || (w_state_nxt == ST_CAPTURE);
      r_frame_done <= w_good;
    end
  end

  assign ready       = r_ready;
  assign frame_done  = r_frame_done;
  assign error_code  = r_err;
  assign pixel_count = r_count;

  frame_buffer_ram #(
    .Depth    (NPix),
    .AddrWidth(17),
    .DataWidth(3)
  ) u_frame_buffer_ram (
    .clk    (clk),
    .i_we   (w_we & ~reset),
    .i_waddr(w_addr),
    .i_wdata(w_pix),
    .i_raddr(rd_addr),
    .o_rdata(rd_data)
  );

endmodule
